// File: rtl/board_game_pkg.sv
// Shared types and the axis-step helper for the N x N board-walk engine.
package board_game_pkg;

   typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_t;

   typedef enum logic [1:0] {READY, MOVE, SCORE, DONE} state_t;

   // One step along an axis: step_dir < 0 decrements, > 0 increments, 0 holds.
   function automatic int unsigned next_coord(input int unsigned coord, input int step_dir,
                                              input bit wrap, input int unsigned side);
      if (step_dir < 0) begin
         if (coord == 0) return wrap ? side - 1 : 0;
         return coord - 1;
      end
      if (step_dir > 0) begin
         if (coord == side - 1) return wrap ? 0 : coord;
         return coord + 1;
      end
      return coord;
   endfunction

endpackage

// File: rtl/board_visit_map.sv
// Per-cell visited bitmap with a running count of distinct cells visited.
module board_visit_map #(
   parameter int unsigned DIM_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  set_en,
   input  logic [2*DIM_LOG2-1:0] query_idx,
   output logic                  hit,
   output logic [2*DIM_LOG2:0]   visited_count
);

   localparam int unsigned Cells = 1 << (2 * DIM_LOG2);

   logic [Cells-1:0] map_q;

   assign hit = map_q[query_idx];

   // The start cell counts as visited, so clearing re-marks cell 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         map_q         <= Cells'(1);
         visited_count <= (2 * DIM_LOG2 + 1)'(1);
      end else if (clear) begin
         map_q         <= Cells'(1);
         visited_count <= (2 * DIM_LOG2 + 1)'(1);
      end else if (set_en && !map_q[query_idx]) begin
         map_q[query_idx] <= 1'b1;
         visited_count    <= visited_count + (2 * DIM_LOG2 + 1)'(1);
      end
   end

endmodule

// File: rtl/board_game_nxn.sv
// Single-player N x N board walk: one move per handshake, first-visit prizes, saturating score.
module board_game_nxn
   import board_game_pkg::*;
#(
   parameter int unsigned DIM_LOG2  = 2,
   parameter int unsigned SUM_W     = 8,
   parameter bit          WRAP      = 1'b1,
   parameter int unsigned MAX_MOVES = 32,
   localparam int unsigned CountW   = (MAX_MOVES == 0) ? 1 : $clog2(MAX_MOVES + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  new_game,
   input  logic                  move_valid,
   output logic                  move_ready,
   input  logic [1:0]            direction,
   output logic [DIM_LOG2-1:0]   x,
   output logic [DIM_LOG2-1:0]   y,
   output logic [2*DIM_LOG2-1:0] place,
   output logic [DIM_LOG2:0]     prize,
   output logic                  prize_valid,
   output logic [SUM_W-1:0]      earned,
   output logic                  earned_sat,
   output logic [2*DIM_LOG2:0]   visited_count,
   output logic [CountW-1:0]     move_count,
   output logic                  game_over
);

   localparam int unsigned N      = 1 << DIM_LOG2;
   localparam int unsigned CellW  = 2 * DIM_LOG2;
   localparam int unsigned PrizeW = DIM_LOG2 + 1;
   localparam int unsigned ExtW   = SUM_W + PrizeW + 1;
   localparam logic [CellW:0]     AllCells  = (CellW + 1)'(1 << CellW);
   localparam logic [SUM_W-1:0]   MaxEarned = '1;

   state_t              state_q, state_d;
   dir_t                dir_q;
   logic                accept, set_en, hit, board_full, limit_hit;
   logic [DIM_LOG2-1:0] nx, ny;
   logic [CellW-1:0]    ncell;
   logic [ExtW-1:0]     sum_ext;

   assign set_en     = (state_q == MOVE) && !new_game;
   assign board_full = (visited_count == AllCells);
   assign limit_hit  = (MAX_MOVES != 0) && (move_count == CountW'(MAX_MOVES));
   assign sum_ext    = ExtW'(earned) + ExtW'(prize);

   board_visit_map #(
      .DIM_LOG2(DIM_LOG2)
   ) u_visit_map (
      .clk          (clk),
      .rst          (reset),
      .clear        (new_game),
      .set_en       (set_en),
      .query_idx    (ncell),
      .hit          (hit),
      .visited_count(visited_count)
   );

   always_comb begin
      nx = x;
      ny = y;
      case (dir_q)
         UP:      ny = DIM_LOG2'(next_coord(int'(y), -1, WRAP, N));
         DOWN:    ny = DIM_LOG2'(next_coord(int'(y), 1, WRAP, N));
         LEFT:    nx = DIM_LOG2'(next_coord(int'(x), -1, WRAP, N));
         default: nx = DIM_LOG2'(next_coord(int'(x), 1, WRAP, N));
      endcase
      ncell = {ny, nx};
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         READY: begin
            if (move_valid) begin
               state_d = MOVE;
               accept  = 1'b1;
            end
         end
         MOVE:    state_d = SCORE;
         SCORE:   state_d = (board_full || limit_hit) ? DONE : READY;
         DONE:    state_d = DONE;
         default: state_d = READY;
      endcase
      if (new_game) begin
         state_d = READY;
         accept  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= READY;      dir_q       <= UP;
         x       <= '0;         y           <= '0;
         place   <= '0;         prize       <= '0;
         earned  <= '0;         earned_sat  <= 1'b0;
         move_count <= '0;      prize_valid <= 1'b0;
         move_ready <= 1'b1;    game_over   <= 1'b0;
      end else if (new_game) begin
         state_q <= READY;      dir_q       <= UP;
         x       <= '0;         y           <= '0;
         place   <= '0;         prize       <= '0;
         earned  <= '0;         earned_sat  <= 1'b0;
         move_count <= '0;      prize_valid <= 1'b0;
         move_ready <= 1'b1;    game_over   <= 1'b0;
      end else begin
         state_q     <= state_d;
         move_ready  <= (state_d == READY);
         game_over   <= (state_d == DONE);
         prize_valid <= 1'b0;
         if (accept) begin
            dir_q      <= dir_t'(direction);
            move_count <= move_count + CountW'(1);
         end
         if (state_q == MOVE) begin
            x     <= nx;
            y     <= ny;
            place <= ncell;
            prize <= hit ? '0 : PrizeW'(nx) + PrizeW'(ny);
         end
         if (state_q == SCORE) begin
            prize_valid <= 1'b1;
            if (sum_ext > ExtW'(MaxEarned)) begin
               earned     <= MaxEarned;
               earned_sat <= 1'b1;
            end else begin
               earned <= sum_ext[SUM_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_board_game_nxn.sv
// Four board configurations driven in lockstep and compared against a behavioural board model.
module tb_board_game_nxn;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       new_game = 1'b0;
   logic       move_valid = 1'b0;
   logic [1:0] direction = 2'b00;

   always #5 clk = ~clk;

   logic [31:0] o_x [4], o_y [4], o_place [4], o_prize [4], o_pv [4], o_earned [4];
   logic [31:0] o_sat [4], o_vc [4], o_mc [4], o_over [4], o_ready [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned DL = (g == 3) ? 1 : 2;
      localparam int unsigned SW = (g == 2) ? 3 : 8;
      localparam bit          WR = (g == 1) ? 1'b0 : 1'b1;
      localparam int unsigned MM = (g == 0) ? 32 : ((g == 1) ? 6 : 0);
      localparam int unsigned MW = (MM == 0) ? 1 : $clog2(MM + 1);
      logic [DL-1:0]   x, y;
      logic [2*DL-1:0] place;
      logic [DL:0]     prize;
      logic [SW-1:0]   earned;
      logic [2*DL:0]   vc;
      logic [MW-1:0]   mc;
      logic            pv, sat, over, ready;

      board_game_nxn #(.DIM_LOG2(DL), .SUM_W(SW), .WRAP(WR), .MAX_MOVES(MM)) dut (
         .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
         .move_ready(ready), .direction(direction), .x(x), .y(y), .place(place),
         .prize(prize), .prize_valid(pv), .earned(earned), .earned_sat(sat),
         .visited_count(vc), .move_count(mc), .game_over(over)
      );

      assign o_x[g] = 32'(x);           assign o_y[g] = 32'(y);
      assign o_place[g] = 32'(place);   assign o_prize[g] = 32'(prize);
      assign o_pv[g] = 32'(pv);         assign o_earned[g] = 32'(earned);
      assign o_sat[g] = 32'(sat);       assign o_vc[g] = 32'(vc);
      assign o_mc[g] = 32'(mc);         assign o_over[g] = 32'(over);
      assign o_ready[g] = 32'(ready);
   end

   int unsigned p_dl [4] = '{2, 2, 2, 1};
   int unsigned p_sw [4] = '{8, 8, 3, 8};
   bit          p_wr [4] = '{1, 0, 1, 1};
   int unsigned p_mm [4] = '{32, 6, 0, 0};
   int unsigned p_mw [4] = '{6, 3, 1, 1};

   int unsigned m_x [4], m_y [4], m_prize [4], m_earned [4], m_vc [4], m_cnt [4];
   bit          m_pv [4], m_sat [4], m_over [4], m_ready [4], m_acc [4];
   bit          vis [4][16];

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string tag, input int i, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
   endtask

   task automatic check_all(input string st);
      for (int i = 0; i < 4; i++) begin
         int unsigned n = 1 << p_dl[i];
         chk({st, ".x"}, i, o_x[i], m_x[i]);
         chk({st, ".y"}, i, o_y[i], m_y[i]);
         chk({st, ".place"}, i, o_place[i], m_y[i] * n + m_x[i]);
         chk({st, ".prize"}, i, o_prize[i], m_prize[i]);
         chk({st, ".prize_valid"}, i, o_pv[i], 32'(m_pv[i]));
         chk({st, ".earned"}, i, o_earned[i], m_earned[i]);
         chk({st, ".earned_sat"}, i, o_sat[i], 32'(m_sat[i]));
         chk({st, ".visited"}, i, o_vc[i], m_vc[i]);
         chk({st, ".move_count"}, i, o_mc[i], m_cnt[i] % (1 << p_mw[i]));
         chk({st, ".game_over"}, i, o_over[i], 32'(m_over[i]));
         chk({st, ".move_ready"}, i, o_ready[i], 32'(m_ready[i]));
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_prize[i] = 0; m_earned[i] = 0; m_cnt[i] = 0;
         m_pv[i] = 0; m_sat[i] = 0; m_over[i] = 0; m_ready[i] = 1; m_acc[i] = 0;
         for (int c = 0; c < 16; c++) vis[i][c] = (c == 0);
         m_vc[i] = 1;
      end
   endtask

   // One move, checked after acceptance, position update and scoring; hold keeps
   // move_valid high (with a scrambled direction) while the engine is busy.
   task automatic do_move(input logic [1:0] d, input bit hold);
      direction  = d;
      move_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         m_acc[i] = m_ready[i];
         m_pv[i]  = 0;
         if (m_acc[i]) begin
            m_cnt[i]++;
            m_ready[i] = 0;
         end
      end
      @(negedge clk);
      check_all("accept");
      if (hold) direction = 2'($urandom_range(0, 3));
      else move_valid = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (m_acc[i]) begin
            int unsigned n = 1 << p_dl[i];
            int unsigned c;
            case (d)
               2'd0: m_y[i] = p_wr[i] ? (m_y[i] + n - 1) % n : (m_y[i] > 0 ? m_y[i] - 1 : 0);
               2'd1: m_y[i] = p_wr[i] ? (m_y[i] + 1) % n : (m_y[i] < n - 1 ? m_y[i] + 1 : m_y[i]);
               2'd2: m_x[i] = p_wr[i] ? (m_x[i] + n - 1) % n : (m_x[i] > 0 ? m_x[i] - 1 : 0);
               default: m_x[i] = p_wr[i] ? (m_x[i] + 1) % n
                                         : (m_x[i] < n - 1 ? m_x[i] + 1 : m_x[i]);
            endcase
            c = m_y[i] * n + m_x[i];
            if (!vis[i][c]) begin
               m_prize[i] = m_x[i] + m_y[i];
               vis[i][c]  = 1;
               m_vc[i]++;
            end else begin
               m_prize[i] = 0;
            end
         end
      end
      @(negedge clk);
      check_all("move");
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (m_acc[i]) begin
            int unsigned top = (1 << p_sw[i]) - 1;
            int unsigned n   = 1 << p_dl[i];
            if (m_earned[i] + m_prize[i] > top) begin
               m_earned[i] = top;
               m_sat[i]    = 1;
            end else begin
               m_earned[i] += m_prize[i];
            end
            m_pv[i]    = 1;
            m_over[i]  = (m_vc[i] == n * n) || (p_mm[i] != 0 && m_cnt[i] == p_mm[i]);
            m_ready[i] = !m_over[i];
         end
      end
      @(negedge clk);
      check_all("score");
      move_valid = 1'b0;
   endtask

   task automatic restart(input bit with_move);
      new_game   = 1'b1;
      move_valid = with_move;
      direction  = 2'($urandom_range(0, 3));
      @(posedge clk);
      model_reset();
      @(negedge clk);
      new_game   = 1'b0;
      move_valid = 1'b0;
      check_all("new_game");
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      reset = 1'b0;
      @(negedge clk);
      check_all("idle");

      do_move(2'd3, 1'b0);
      do_move(2'd3, 1'b0);
      do_move(2'd1, 1'b0);

      restart(1'b1);
      do_move(2'd2, 1'b0);
      do_move(2'd0, 1'b1);

      restart(1'b0);
      do_move(2'd3, 1'b1);
      do_move(2'd2, 1'b0);

      restart(1'b0);
      do_move(2'd3, 1'b0);
      do_move(2'd3, 1'b0);
      do_move(2'd3, 1'b0);
      do_move(2'd1, 1'b0);
      do_move(2'd1, 1'b1);
      do_move(2'd2, 1'b0);

      for (int r = 0; r < 2; r++) begin
         restart(1'($urandom_range(0, 1)));
         for (int k = 0; k < 30; k++) do_move(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // Reset lands while the accepted move is in flight.
      restart(1'b0);
      direction  = 2'd3;
      move_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      check_all("rst_mid");
      @(posedge clk);
      @(negedge clk);
      check_all("rst_hold");
      reset = 1'b0;
      #1;
      check_all("rst_rel");
      move_valid = 1'b0;
      @(negedge clk);
      do_move(2'd1, 1'b0);
      do_move(2'd3, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
